mul_issue_queue: RTL and testbench
==================================

Name: mul_issue_queue

Overview:
- Reservation station for the multiply functional unit: holds dispatched multiply µops and wakes pending operands from CDB broadcasts.
- Issues the oldest ready entry to the shift-add multiplier using the start/done protocol.
- Sits between rename/dispatch and the multiplier. The multiplier's CDB result path and cdb_mul_ack arbitration are outside this block.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
OPERAND_WIDTH, 32, operand data width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
branch  in  1  flush: clear all entries, abort in-flight issue
dispatch_valid  in  1  µop presented this cycle
dispatch_ready  out  1  queue can accept (count < DEPTH)
disp_mul_type  in  2  11 unsigned*unsigned, 00 signed*signed, 10 signed(a)*unsigned(b)
disp_ps1, disp_ps2  in  PR_WIDTH each  source physical tags
disp_ps1_rdy, disp_ps2_rdy  in  1 each  source value already valid
disp_ps1_data, disp_ps2_data  in  OPERAND_WIDTH each  source value (used only when rdy)
disp_arch_reg  in  5  destination architectural register
disp_phys_reg  in  PR_WIDTH  destination physical tag
disp_rob  in  ROB_WIDTH  ROB index
cdb_valid  in  1  CDB broadcast valid
cdb_phys_reg  in  PR_WIDTH  broadcast tag
cdb_data  in  32  broadcast value
mul_start  out  1  start to multiplier (registered)
mul_a, mul_b  out  OPERAND_WIDTH each  operands (registered, stable while mul_start=1)
mul_type  out  2  multiply type
mul_arch_reg, mul_phys_reg, mul_rob  out  5/PR_WIDTH/ROB_WIDTH  tags for the issued op
mul_done  in  1  multiplier done flag
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset/flush (rst or branch): all entries invalid, count=0, FSM=IDLE, mul_start=0. All mul_* operand/tag outputs=0. dispatch_ready=1 on the following cycle.
- Collapsing queue: entry 0 is oldest. On removal, entries above the removed one shift down by one in the same clock edge.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready. dispatch_ready depends on registered count only, not on a same-cycle issue.
  - Written at slot count, or count-1 when an issue removes an entry in the same cycle.
- Wakeup: every valid entry with a source not ready and tag == cdb_phys_reg while cdb_valid captures cdb_data and sets ready.
  - Same-cycle bypass applies to a µop being dispatched: a matching tag is stored as ready with cdb_data.
- Selection: lowest-index valid entry with both sources ready (registered ready bits only; no same-cycle wakeup-to-issue).
- Issue FSM:
  - IDLE: mul_start=0. If a ready entry exists and mul_done=1 (multiplier idle):
    - register its operands and tags onto mul_*;
    - remove the entry;
    - set mul_start=1 next cycle;
    - go to BUSY.
  - BUSY: mul_start=1, mul_* held. Stay while mul_done=0. When mul_done=1 (result acknowledged onto CDB), go to RELEASE.
    - In the first BUSY cycle the multiplier reports done=0; this is not completion.
  - RELEASE: mul_start=0 for exactly one cycle, then go to IDLE. No issue occurs in RELEASE.
- Latency:
  - A µop dispatched with both sources ready at cycle N is valid at N+1 and mul_start rises at N+2, if the FSM is IDLE and the multiplier is idle.
  - Minimum spacing between consecutive starts = multiplier latency + 2 cycles.
- Full: dispatch_valid with count==DEPTH is ignored; no state change.
- Simultaneous dispatch, issue and wakeup in one cycle are all legal and must all take effect.
- branch during BUSY: mul_start drops on the next cycle. The in-flight operation is discarded; the multiplier flushes on the same signal.

Test Plan:
- Dispatch a=7, b=6, type=11, both ready, idle multiplier model (done=1) -> mul_start=1 two cycles later with mul_a=7, mul_b=6. Hold until done pulses, then one cycle of start=0 and count returns to 0.
- Dispatch ps1=5 not ready, then CDB tag 5 with data 0xFFFFFFFD -> entry issues with mul_a=0xFFFFFFFD; no issue before the wakeup cycle+1.
- Fill 4 entries (count=4) -> dispatch_ready=0; a 5th dispatch is dropped. After one issue, count=3 and dispatch_ready=1.
- Entry0 waiting, entry1 ready -> entry1 issues first; entry0 shifts and issues after wakeup. rob order matches ready order.
- Dispatch with CDB tag match in the same cycle -> stored ready, issues on the minimum-latency path.
- branch asserted while BUSY with 3 entries -> next cycle count=0, mul_start=0, FSM IDLE; a new dispatch issues normally.

Source files
------------

// File: rtl/mul_issue_queue.sv
// mul_issue_queue: reservation station in front of the shift-add multiplier.
//
// Holds dispatched multiply uops in a collapsing queue. Entry 0 is always the
// oldest. Pending source operands are woken by CDB broadcasts. The oldest
// entry whose sources are both ready is issued to the multiplier through a
// start/done handshake.
//
// Handshakes:
//   dispatch : a uop transfers on a clock edge where dispatch_valid and
//              dispatch_ready are both 1. dispatch_ready depends only on the
//              registered count, so it does not combinationally depend on
//              dispatch_valid.
//   multiply : mul_start is held high with stable mul_* for the whole
//              operation. The queue only starts when mul_done=1, meaning the
//              multiplier is idle. The same mul_done=1 seen while BUSY means
//              the result was taken. After that, mul_start is low for one
//              cycle so the multiplier can see the operation end.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   branch          flush: drop all entries and abort any in-flight issue
//   dispatch_*/disp_*  incoming uop (types, source tags/data, dest tags, ROB)
//   cdb_*           result broadcast used for operand wakeup
//   mul_*           issued operation towards the multiplier, mul_done back
//   count           occupied entries
//   fsm_state       issue FSM state (0 IDLE, 1 BUSY, 2 RELEASE), debug view
module mul_issue_queue #(
    parameter int DEPTH         = 4,
    parameter int OPERAND_WIDTH = 32,
    parameter int PR_WIDTH      = 6,
    parameter int ROB_WIDTH     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       branch,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  logic [1:0]                 disp_mul_type,
    input  logic [PR_WIDTH-1:0]        disp_ps1,
    input  logic [PR_WIDTH-1:0]        disp_ps2,
    input  logic                       disp_ps1_rdy,
    input  logic                       disp_ps2_rdy,
    input  logic [OPERAND_WIDTH-1:0]   disp_ps1_data,
    input  logic [OPERAND_WIDTH-1:0]   disp_ps2_data,
    input  logic [4:0]                 disp_arch_reg,
    input  logic [PR_WIDTH-1:0]        disp_phys_reg,
    input  logic [ROB_WIDTH-1:0]       disp_rob,
    input  logic                       cdb_valid,
    input  logic [PR_WIDTH-1:0]        cdb_phys_reg,
    input  logic [OPERAND_WIDTH-1:0]   cdb_data,
    output logic                       mul_start,
    output logic [OPERAND_WIDTH-1:0]   mul_a,
    output logic [OPERAND_WIDTH-1:0]   mul_b,
    output logic [1:0]                 mul_type,
    output logic [4:0]                 mul_arch_reg,
    output logic [PR_WIDTH-1:0]        mul_phys_reg,
    output logic [ROB_WIDTH-1:0]       mul_rob,
    input  logic                       mul_done,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 fsm_state
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic                     valid;
        logic                     rdy1;
        logic                     rdy2;
        logic [PR_WIDTH-1:0]      tag1;
        logic [PR_WIDTH-1:0]      tag2;
        logic [OPERAND_WIDTH-1:0] data1;
        logic [OPERAND_WIDTH-1:0] data2;
        logic [1:0]               mtype;
        logic [4:0]               arch;
        logic [PR_WIDTH-1:0]      phys;
        logic [ROB_WIDTH-1:0]     rob;
    } entry_t;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

    entry_t          q     [DEPTH];
    entry_t          woke  [DEPTH];
    entry_t          q_d   [DEPTH];
    entry_t          disp_e;
    state_t          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   wr_idx;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic            issue_fire;
    logic            disp_fire;

    assign dispatch_ready = (count_q < CW'(DEPTH));
    assign count          = count_q;
    assign fsm_state      = state_q;

    // Wakeup: resident entries with a pending source capture a matching broadcast.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = q[i];
            if (cdb_valid && q[i].valid) begin
                if (!q[i].rdy1 && q[i].tag1 == cdb_phys_reg) begin
                    woke[i].rdy1  = 1'b1;
                    woke[i].data1 = cdb_data;
                end
                if (!q[i].rdy2 && q[i].tag2 == cdb_phys_reg) begin
                    woke[i].rdy2  = 1'b1;
                    woke[i].data2 = cdb_data;
                end
            end
        end
    end

    // Incoming uop, with a same-cycle bypass from the CDB for pending sources.
    always_comb begin
        disp_e       = '0;
        disp_e.valid = 1'b1;
        disp_e.tag1  = disp_ps1;
        disp_e.tag2  = disp_ps2;
        disp_e.rdy1  = disp_ps1_rdy;
        disp_e.rdy2  = disp_ps2_rdy;
        disp_e.data1 = disp_ps1_data;
        disp_e.data2 = disp_ps2_data;
        disp_e.mtype = disp_mul_type;
        disp_e.arch  = disp_arch_reg;
        disp_e.phys  = disp_phys_reg;
        disp_e.rob   = disp_rob;
        if (cdb_valid && !disp_ps1_rdy && disp_ps1 == cdb_phys_reg) begin
            disp_e.rdy1  = 1'b1;
            disp_e.data1 = cdb_data;
        end
        if (cdb_valid && !disp_ps2_rdy && disp_ps2 == cdb_phys_reg) begin
            disp_e.rdy2  = 1'b1;
            disp_e.data2 = cdb_data;
        end
    end

    // Oldest ready entry. Only registered ready bits count, so a wakeup
    // becomes visible to selection one cycle later.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rdy1 && q[i].rdy2) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign issue_fire = (state_q == IDLE) && sel_found && mul_done && !branch;
    assign disp_fire  = dispatch_valid && dispatch_ready && !branch;
    // Each removal shifts the queue down, so the free slot moves down with it.
    assign wr_idx     = count_q - {{(CW-1){1'b0}}, issue_fire};

    // Next queue contents: collapse above the issued slot, then append.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && i >= int'(sel_idx)) begin
                q_d[i] = (i == DEPTH - 1) ? '0 : woke[(i + 1) % DEPTH];
            end else begin
                q_d[i] = woke[i];
            end
            if (disp_fire && wr_idx == CW'(i)) begin
                q_d[i] = disp_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || branch) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_d[i];
            count_q <= count_q + {{(CW-1){1'b0}}, disp_fire}
                               - {{(CW-1){1'b0}}, issue_fire};
        end
    end

    // Issue FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_fire) state_d = BUSY;
            BUSY:    if (mul_done)   state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (branch) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || branch) begin
            state_q      <= IDLE;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_type     <= '0;
            mul_arch_reg <= '0;
            mul_phys_reg <= '0;
            mul_rob      <= '0;
        end else begin
            state_q   <= state_d;
            mul_start <= (state_d == BUSY);
            if (issue_fire) begin
                mul_a        <= q[sel_idx].data1;
                mul_b        <= q[sel_idx].data2;
                mul_type     <= q[sel_idx].mtype;
                mul_arch_reg <= q[sel_idx].arch;
                mul_phys_reg <= q[sel_idx].phys;
                mul_rob      <= q[sel_idx].rob;
            end
        end
    end
endmodule

// File: tb/tb_mul_issue_queue.sv
// Directed bench for mul_issue_queue with a behavioural multiplier handshake
// model and an issue-order scoreboard.
module tb_mul_issue_queue;
    localparam int OW   = 32;
    localparam int PRW  = 6;
    localparam int ROBW = 5;
    localparam int LAT  = 3;
    localparam int SBW  = ROBW + 2 * OW;

    logic            clk = 1'b0;
    logic            rst;
    logic            branch;
    logic            dispatch_valid;
    logic            dispatch_ready;
    logic [1:0]      disp_mul_type;
    logic [PRW-1:0]  disp_ps1, disp_ps2;
    logic            disp_ps1_rdy, disp_ps2_rdy;
    logic [OW-1:0]   disp_ps1_data, disp_ps2_data;
    logic [4:0]      disp_arch_reg;
    logic [PRW-1:0]  disp_phys_reg;
    logic [ROBW-1:0] disp_rob;
    logic            cdb_valid;
    logic [PRW-1:0]  cdb_phys_reg;
    logic [OW-1:0]   cdb_data;
    logic            mul_start;
    logic [OW-1:0]   mul_a, mul_b;
    logic [1:0]      mul_type;
    logic [4:0]      mul_arch_reg;
    logic [PRW-1:0]  mul_phys_reg;
    logic [ROBW-1:0] mul_rob;
    logic            mul_done;
    logic [2:0]      count;
    logic [1:0]      fsm_state;

    int total = 0;
    int bad   = 0;
    logic [SBW-1:0] exp_q[$];

    mul_issue_queue #(.DEPTH(4), .OPERAND_WIDTH(OW), .PR_WIDTH(PRW), .ROB_WIDTH(ROBW)) dut (
        .clk(clk), .rst(rst), .branch(branch),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .disp_mul_type(disp_mul_type),
        .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
        .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
        .disp_ps1_data(disp_ps1_data), .disp_ps2_data(disp_ps2_data),
        .disp_arch_reg(disp_arch_reg), .disp_phys_reg(disp_phys_reg), .disp_rob(disp_rob),
        .cdb_valid(cdb_valid), .cdb_phys_reg(cdb_phys_reg), .cdb_data(cdb_data),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_type(mul_type),
        .mul_arch_reg(mul_arch_reg), .mul_phys_reg(mul_phys_reg), .mul_rob(mul_rob),
        .mul_done(mul_done), .count(count), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- multiplier model ----------------
    // Idle: done=1 unless start is being presented. Runs LAT cycles, then
    // reports done until start is released.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t m_state;
    int      m_cnt;

    always @(posedge clk) begin
        if (rst || branch) begin
            m_state <= M_IDLE;
            m_cnt   <= 0;
        end else begin
            case (m_state)
                M_IDLE: if (mul_start) begin m_state <= M_RUN; m_cnt <= LAT; end
                M_RUN:  if (m_cnt == 1) m_state <= M_DONE; else m_cnt <= m_cnt - 1;
                M_DONE: if (!mul_start) m_state <= M_IDLE;
                default: m_state <= M_IDLE;
            endcase
        end
    end
    assign mul_done = (m_state == M_IDLE && !mul_start) || (m_state == M_DONE);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [SBW-1:0] obs, input logic [SBW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rising mul_start must match the next expected issue.
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_start <= 1'b0;
        end else begin
            if (mul_start && !prev_start) begin
                check("sb_has_entry", SBW'(exp_q.size() != 0), SBW'(1));
                if (exp_q.size() != 0) check("issue_sb", {mul_rob, mul_a, mul_b}, exp_q.pop_front());
            end
            prev_start <= mul_start;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        branch         = 1'b0;
    endtask

    task automatic drive_disp(input logic [1:0] t,
                              input logic [PRW-1:0] p1, input logic r1, input logic [OW-1:0] d1,
                              input logic [PRW-1:0] p2, input logic r2, input logic [OW-1:0] d2,
                              input logic [ROBW-1:0] rob);
        dispatch_valid = 1'b1;
        disp_mul_type  = t;
        disp_ps1       = p1;
        disp_ps1_rdy   = r1;
        disp_ps1_data  = d1;
        disp_ps2       = p2;
        disp_ps2_rdy   = r2;
        disp_ps2_data  = d2;
        disp_arch_reg  = 5'(rob);
        disp_phys_reg  = PRW'(rob) + PRW'(32);
        disp_rob       = rob;
    endtask

    task automatic drive_cdb(input logic [PRW-1:0] tag, input logic [OW-1:0] d);
        cdb_valid    = 1'b1;
        cdb_phys_reg = tag;
        cdb_data     = d;
    endtask

    // Wait (bounded) for the current operation to end, then through RELEASE.
    task automatic finish_op();
        int g;
        g = 0;
        while (mul_start && g < 40) begin
            tick();
            g++;
        end
        check("finish_timeout", SBW'(g < 40), SBW'(1));
        check("release_state", SBW'(fsm_state), SBW'(2));
        check("release_start", SBW'(mul_start), SBW'(0));
        tick();
        check("back_idle", SBW'(fsm_state), SBW'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hi;
        int g;
        rst = 1'b1;
        clear_inputs();
        drive_disp(2'b00, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        dispatch_valid = 1'b0;
        drive_cdb('0, '0);
        cdb_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", SBW'(count), SBW'(0));
        check("rst_ready", SBW'(dispatch_ready), SBW'(1));
        check("rst_start", SBW'(mul_start), SBW'(0));
        check("rst_mul_a", SBW'(mul_a), SBW'(0));
        check("rst_rob", SBW'(mul_rob), SBW'(0));
        check("rst_fsm", SBW'(fsm_state), SBW'(0));

        // 1: ready uop 7*6 unsigned, start two cycles after dispatch
        drive_disp(2'b11, 6'd1, 1'b1, 32'd7, 6'd2, 1'b1, 32'd6, 5'd1);
        exp_q.push_back({5'd1, 32'd7, 32'd6});
        tick();
        clear_inputs();
        check("t1_count_after_disp", SBW'(count), SBW'(1));
        check("t1_no_start_yet", SBW'(mul_start), SBW'(0));
        tick();
        check("t1_start", SBW'(mul_start), SBW'(1));
        check("t1_a", SBW'(mul_a), SBW'(7));
        check("t1_b", SBW'(mul_b), SBW'(6));
        check("t1_type", SBW'(mul_type), SBW'(3));
        check("t1_phys", SBW'(mul_phys_reg), SBW'(33));
        check("t1_arch", SBW'(mul_arch_reg), SBW'(1));
        check("t1_count_issued", SBW'(count), SBW'(0));
        // start high: handshake cycle + LAT run cycles + done cycle
        hi = 1;
        g  = 0;
        while (mul_start && g < 40) begin
            tick();
            g++;
            if (mul_start) hi++;
        end
        check("t1_start_width", SBW'(hi), SBW'(LAT + 2));
        check("t1_release", SBW'(fsm_state), SBW'(2));
        tick();
        check("t1_idle", SBW'(fsm_state), SBW'(0));
        check("t1_start_low", SBW'(mul_start), SBW'(0));

        // 2: pending source woken by CDB
        drive_disp(2'b00, 6'd5, 1'b0, 32'd0, 6'd7, 1'b1, 32'd3, 5'd2);
        exp_q.push_back({5'd2, 32'hFFFF_FFFD, 32'd3});
        tick();
        clear_inputs();
        check("t2_count", SBW'(count), SBW'(1));
        tick();
        tick();
        check("t2_no_issue_waiting", SBW'(mul_start), SBW'(0));
        drive_cdb(6'd5, 32'hFFFF_FFFD);
        tick();
        clear_inputs();
        check("t2_no_issue_wake_cycle", SBW'(mul_start), SBW'(0));
        tick();
        check("t2_start", SBW'(mul_start), SBW'(1));
        check("t2_a", SBW'(mul_a), SBW'(32'hFFFF_FFFD));
        check("t2_rob", SBW'(mul_rob), SBW'(2));
        check("t2_type", SBW'(mul_type), SBW'(0));
        finish_op();

        // 3: fill the queue, drop a fifth dispatch, then drain in order
        for (int k = 0; k < 4; k++) begin
            drive_disp(2'b11, 6'd20, 1'b0, 32'd0, PRW'(21 + k), 1'b1, OW'(k + 1), ROBW'(3 + k));
            exp_q.push_back({ROBW'(3 + k), 32'd100, OW'(k + 1)});
            tick();
        end
        clear_inputs();
        check("t3_full_count", SBW'(count), SBW'(4));
        check("t3_full_ready", SBW'(dispatch_ready), SBW'(0));
        drive_disp(2'b11, 6'd1, 1'b1, 32'd55, 6'd2, 1'b1, 32'd66, 5'd7);
        tick();
        clear_inputs();
        check("t3_dropped_count", SBW'(count), SBW'(4));
        drive_cdb(6'd20, 32'd100);
        tick();
        clear_inputs();
        check("t3_wake_no_start", SBW'(mul_start), SBW'(0));
        tick();
        check("t3_start", SBW'(mul_start), SBW'(1));
        check("t3_rob", SBW'(mul_rob), SBW'(3));
        check("t3_count_after_issue", SBW'(count), SBW'(3));
        check("t3_ready_after_issue", SBW'(dispatch_ready), SBW'(1));
        g = 0;
        while (!(count == 0 && fsm_state == 2'd0 && !mul_start) && g < 200) begin
            tick();
            g++;
        end
        check("t3_drain_timeout", SBW'(g < 200), SBW'(1));

        // 4: younger ready entry bypasses an older waiting one
        drive_disp(2'b11, 6'd30, 1'b0, 32'd0, 6'd31, 1'b1, 32'd2, 5'd8);
        tick();
        drive_disp(2'b11, 6'd3, 1'b1, 32'd11, 6'd4, 1'b1, 32'd12, 5'd9);
        exp_q.push_back({5'd9, 32'd11, 32'd12});
        exp_q.push_back({5'd8, 32'd40, 32'd2});
        tick();
        clear_inputs();
        check("t4_count", SBW'(count), SBW'(2));
        tick();
        check("t4_first_start", SBW'(mul_start), SBW'(1));
        check("t4_first_rob", SBW'(mul_rob), SBW'(9));
        check("t4_count_left", SBW'(count), SBW'(1));
        drive_cdb(6'd30, 32'd40);
        tick();
        clear_inputs();
        finish_op();
        tick();
        check("t4_second_start", SBW'(mul_start), SBW'(1));
        check("t4_second_rob", SBW'(mul_rob), SBW'(8));
        check("t4_second_a", SBW'(mul_a), SBW'(40));
        finish_op();

        // 5: same-cycle CDB bypass at dispatch
        drive_disp(2'b10, 6'd40, 1'b0, 32'd0, 6'd41, 1'b1, 32'd5, 5'd10);
        drive_cdb(6'd40, 32'h1234);
        exp_q.push_back({5'd10, 32'h1234, 32'd5});
        tick();
        clear_inputs();
        check("t5_count", SBW'(count), SBW'(1));
        check("t5_no_start", SBW'(mul_start), SBW'(0));
        tick();
        check("t5_start", SBW'(mul_start), SBW'(1));
        check("t5_a", SBW'(mul_a), SBW'(32'h1234));
        finish_op();

        // 6: flush while BUSY with three entries waiting
        drive_disp(2'b11, 6'd1, 1'b1, 32'd2, 6'd2, 1'b1, 32'd3, 5'd11);
        exp_q.push_back({5'd11, 32'd2, 32'd3});
        tick();
        check("t6_count1", SBW'(count), SBW'(1));
        drive_disp(2'b11, 6'd1, 1'b1, 32'd4, 6'd2, 1'b1, 32'd5, 5'd12);
        tick();
        check("t6_start", SBW'(mul_start), SBW'(1));
        check("t6_rob", SBW'(mul_rob), SBW'(11));
        check("t6_disp_and_issue_count", SBW'(count), SBW'(1));
        drive_disp(2'b11, 6'd1, 1'b1, 32'd6, 6'd2, 1'b1, 32'd7, 5'd13);
        tick();
        drive_disp(2'b11, 6'd1, 1'b1, 32'd8, 6'd2, 1'b1, 32'd9, 5'd14);
        tick();
        clear_inputs();
        check("t6_count3", SBW'(count), SBW'(3));
        check("t6_busy", SBW'(fsm_state), SBW'(1));
        branch = 1'b1;
        tick();
        clear_inputs();
        check("t6_flush_count", SBW'(count), SBW'(0));
        check("t6_flush_start", SBW'(mul_start), SBW'(0));
        check("t6_flush_fsm", SBW'(fsm_state), SBW'(0));
        check("t6_flush_a", SBW'(mul_a), SBW'(0));
        check("t6_flush_rob", SBW'(mul_rob), SBW'(0));
        check("t6_flush_ready", SBW'(dispatch_ready), SBW'(1));
        drive_disp(2'b10, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd9, 5'd15);
        exp_q.push_back({5'd15, 32'd9, 32'd9});
        tick();
        clear_inputs();
        check("t6_new_count", SBW'(count), SBW'(1));
        tick();
        check("t6_new_start", SBW'(mul_start), SBW'(1));
        check("t6_new_rob", SBW'(mul_rob), SBW'(15));
        check("t6_new_type", SBW'(mul_type), SBW'(2));
        finish_op();

        check("sb_drained", SBW'(exp_q.size()), SBW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
